// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - two-requester round-robin arbiter driving a memory-mapped SPI controller
module spi_xfer_arbiter #(
  parameter logic [9:0]  MODE_CFG = 10'h0D7,
  parameter logic [15:0] CLK_DIV  = 16'h0063,
  parameter int          TIMEOUT  = 1023
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  REQ,
  input  logic [7:0]  TX0,
  input  logic [7:0]  TX1,
  output logic [1:0]  GNT,
  output logic        DONE,
  output logic [7:0]  RX_DATA,
  output logic        ERR,
  output logic        BUSY,
  output logic        MST_CEn,
  output logic        MST_WEn,
  output logic [31:0] MST_ADDR,
  output logic [31:0] MST_WDATA,
  input  logic [31:0] MST_RDATA
);

  localparam logic [31:0] ADDR_SPCR = 32'h0000_0000;
  localparam logic [31:0] ADDR_SPSR = 32'h0000_0004;
  localparam logic [31:0] ADDR_DIV  = 32'h0000_000C;
  localparam logic [31:0] ADDR_TX   = 32'h0000_0010;
  localparam logic [31:0] ADDR_RX   = 32'h0000_0014;
  localparam logic [9:0]  TIMEOUT_CNT = 10'(TIMEOUT);

  typedef enum logic [3:0] {
    INIT_MODE,
    INIT_CLK,
    IDLE,
    XFER_WR,
    POLL,
    CHK,
    RD_RX,
    CAP,
    FIN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  // Cleared by reset so the reset-following cycle shows idle outputs before INIT_MODE strobes.
  logic        started;
  // Index of the requester served most recently; reset to 1 so requester 0 wins first.
  logic        last_served;
  logic        pick;
  logic [9:0]  poll_cnt;
  logic        cen_nxt;
  logic        wen_nxt;
  logic [31:0] addr_nxt;
  logic [31:0] wdata_nxt;
  logic        unused_rdata;

  // Only the low byte carries RX data; bit 0 doubles as the SPSR ready flag.
  assign unused_rdata = ^MST_RDATA[31:8];

  // Round-robin choice: a lone requester wins, with two the one not served last wins.
  always_comb begin
    pick = 1'b0;
    case (REQ)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_served;
      default: pick = 1'b0;
    endcase
  end

  // Next-state logic for the init / transfer / poll sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT_MODE: state_nxt = started ? INIT_CLK : INIT_MODE;
      INIT_CLK:  state_nxt = IDLE;
      IDLE:      state_nxt = (REQ != 2'b00) ? XFER_WR : IDLE;
      XFER_WR:   state_nxt = POLL;
      POLL:      state_nxt = CHK;
      CHK: begin
        if (MST_RDATA[0]) begin
          state_nxt = RD_RX;
        end else if (poll_cnt < TIMEOUT_CNT) begin
          state_nxt = POLL;
        end else begin
          state_nxt = FIN;
        end
      end
      RD_RX:     state_nxt = CAP;
      CAP:       state_nxt = FIN;
      FIN:       state_nxt = IDLE;
      default:   state_nxt = INIT_MODE;
    endcase
  end

  // Bus strobe for the state being entered, so registered bus outputs line up with the state.
  always_comb begin
    cen_nxt   = 1'b1;
    wen_nxt   = 1'b1;
    addr_nxt  = 32'h0;
    wdata_nxt = 32'h0;
    case (state_nxt)
      INIT_MODE: begin
        cen_nxt   = 1'b0;
        wen_nxt   = 1'b0;
        addr_nxt  = ADDR_SPCR;
        wdata_nxt = {22'b0, MODE_CFG};
      end
      INIT_CLK: begin
        cen_nxt   = 1'b0;
        wen_nxt   = 1'b0;
        addr_nxt  = ADDR_DIV;
        wdata_nxt = {16'b0, CLK_DIV};
      end
      XFER_WR: begin
        // Only reachable from IDLE, so the live TX of the winner is the byte latched here.
        cen_nxt   = 1'b0;
        wen_nxt   = 1'b0;
        addr_nxt  = ADDR_TX;
        wdata_nxt = {24'b0, (pick ? TX1 : TX0)};
      end
      POLL: begin
        cen_nxt  = 1'b0;
        addr_nxt = ADDR_SPSR;
      end
      RD_RX: begin
        cen_nxt  = 1'b0;
        addr_nxt = ADDR_RX;
      end
      default: begin
      end
    endcase
  end

  // State register, registered outputs, grant bookkeeping and result capture.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= INIT_MODE;
      started     <= 1'b0;
      last_served <= 1'b1;
      poll_cnt    <= 10'd0;
      GNT         <= 2'b00;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      RX_DATA     <= 8'h00;
      BUSY        <= 1'b1;
      MST_CEn     <= 1'b1;
      MST_WEn     <= 1'b1;
      MST_ADDR    <= 32'h0;
      MST_WDATA   <= 32'h0;
    end else begin
      state     <= state_nxt;
      started   <= 1'b1;
      MST_CEn   <= cen_nxt;
      MST_WEn   <= wen_nxt;
      MST_ADDR  <= addr_nxt;
      MST_WDATA <= wdata_nxt;
      BUSY      <= (state_nxt != IDLE);
      DONE      <= (state_nxt == FIN);

      if (state == IDLE && state_nxt == XFER_WR) begin
        GNT         <= pick ? 2'b10 : 2'b01;
        last_served <= pick;
        poll_cnt    <= 10'd0;
      end else if (state == FIN) begin
        GNT <= 2'b00;
      end

      // Saturate so the count can never wrap below the timeout compare.
      if (state_nxt == POLL && poll_cnt != 10'h3FF) begin
        poll_cnt <= poll_cnt + 10'd1;
      end

      if (state == CAP) begin
        RX_DATA <= MST_RDATA[7:0];
        ERR     <= 1'b0;
      end else if (state == CHK && state_nxt == FIN) begin
        RX_DATA <= 8'h00;
        ERR     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb/tb_spi_xfer_arbiter.sv - scoreboard bench for spi_xfer_arbiter
module tb_spi_xfer_arbiter;

  localparam int TB_TIMEOUT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  REQ;
  logic [7:0]  TX0;
  logic [7:0]  TX1;
  logic [1:0]  GNT;
  logic        DONE;
  logic [7:0]  RX_DATA;
  logic        ERR;
  logic        BUSY;
  logic        MST_CEn;
  logic        MST_WEn;
  logic [31:0] MST_ADDR;
  logic [31:0] MST_WDATA;
  logic [31:0] MST_RDATA;

  spi_xfer_arbiter #(
    .MODE_CFG(10'h0D7),
    .CLK_DIV (16'h0063),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .REQ      (REQ),
    .TX0      (TX0),
    .TX1      (TX1),
    .GNT      (GNT),
    .DONE     (DONE),
    .RX_DATA  (RX_DATA),
    .ERR      (ERR),
    .BUSY     (BUSY),
    .MST_CEn  (MST_CEn),
    .MST_WEn  (MST_WEn),
    .MST_ADDR (MST_ADDR),
    .MST_WDATA(MST_WDATA),
    .MST_RDATA(MST_RDATA)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int checks_total  = 0;
  int checks_passed = 0;

  // expected bus ops {wen, addr, wdata} and expected completions {gnt, rx, err}
  logic [64:0] exp_bus[$];
  logic [10:0] exp_done[$];

  // SPI controller model state
  int          polls_seen = 0;
  int          cur_misses = 0;
  logic [7:0]  cur_rx     = 8'h00;
  logic [31:0] slave_word;

  // reference arbitration state: 1 means requester 1 was served last
  bit last_served = 1'b1;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic fail(input string name, input string what);
    checks_total++;
    $display("FAIL %s: got %s", name, what);
  endtask

  // controller model: status reads miss cur_misses times then report ready
  always @(negedge CLK) begin
    if (!RESET && !MST_CEn) begin
      if (!MST_WEn && MST_ADDR == 32'h10) begin
        polls_seen = 0;
      end else if (MST_WEn && MST_ADDR == 32'h04) begin
        slave_word    = $urandom;
        slave_word[0] = (polls_seen >= cur_misses);
        MST_RDATA     = slave_word;
        polls_seen++;
      end else if (MST_WEn && MST_ADDR == 32'h14) begin
        slave_word      = $urandom;
        slave_word[7:0] = cur_rx;
        MST_RDATA       = slave_word;
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT strobes the bus or pulses DONE
  always @(negedge CLK) begin
    logic [64:0] eb;
    logic [10:0] ed;
    if (!MST_CEn) begin
      if (exp_bus.size() == 0) begin
        fail("bus_op", $sformatf("unexpected op we_n=%0b addr=%0h data=%0h, required none", MST_WEn, MST_ADDR, MST_WDATA));
      end else begin
        eb = exp_bus.pop_front();
        check("bus_op", 96'({MST_WEn, MST_ADDR, MST_WDATA}), 96'(eb));
      end
    end else if (!MST_WEn) begin
      fail("idle_wen", "MST_WEn=0 without strobe, required 1");
    end
    if (DONE) begin
      if (exp_done.size() == 0) begin
        fail("done_resp", "unexpected DONE, required none");
      end else begin
        ed = exp_done.pop_front();
        check("done_resp", 96'({GNT, RX_DATA, ERR}), 96'(ed));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    if (BUSY !== 1'b0) fail("idle_wait", "BUSY stuck high, required 0");
  endtask

  task automatic push_init();
    exp_bus.push_back({1'b0, 32'h00, 32'h0000_00D7});
    exp_bus.push_back({1'b0, 32'h0C, 32'h0000_0063});
  endtask

  // one transfer: reference model predicts grant, bus ops and result, then drives REQ
  task automatic xfer(input logic [1:0] req, input logic [7:0] t0, input logic [7:0] t1,
                      input int misses, input logic [7:0] rx, input bit drop, input bit keep,
                      output int lat);
    bit         g;
    int         npoll;
    int         n;
    int         start;
    logic [7:0] txg;
    wait_idle();
    g = (req == 2'b11) ? ~last_served : req[1];
    last_served = g;
    txg = g ? t1 : t0;
    cur_misses = misses;
    cur_rx     = rx;
    npoll = (misses >= TB_TIMEOUT) ? TB_TIMEOUT : misses + 1;
    exp_bus.push_back({1'b0, 32'h10, 24'h0, txg});
    repeat (npoll) exp_bus.push_back({1'b1, 32'h04, 32'h0});
    if (misses < TB_TIMEOUT) exp_bus.push_back({1'b1, 32'h14, 32'h0});
    exp_done.push_back({(g ? 2'b10 : 2'b01), ((misses < TB_TIMEOUT) ? rx : 8'h00), (misses >= TB_TIMEOUT)});
    REQ   = req;
    TX0   = t0;
    TX1   = t1;
    start = cyc;
    tick();
    if (drop) begin
      REQ = 2'b00;
      TX0 = 8'hFF;
      TX1 = 8'hFF;
    end
    n = 0;
    while (DONE !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (DONE !== 1'b1) fail("done_wait", "no DONE within budget, required DONE");
    lat = cyc - start;
    if (!keep) REQ = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    RESET = 1'b1;
    REQ = 2'b00;
    TX0 = 8'h00;
    TX1 = 8'h00;
    MST_RDATA = 32'h0;
    repeat (3) tick();
    check("reset_outputs", 96'({GNT, DONE, ERR, RX_DATA, BUSY, MST_CEn, MST_WEn, MST_ADDR, MST_WDATA}),
          96'({2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0}));
    push_init();
    RESET = 1'b0;
    n = 0;
    while (BUSY !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("init_len", 96'(n), 96'(3));

    // both requesting, held across transfers: grant order 01, 10, 01
    xfer(2'b11, 8'h11, 8'h22, 0, 8'h5A, 1'b0, 1'b1, lat);
    check("rr_order_0", 96'(GNT), 96'(2'b01));
    xfer(2'b11, 8'h33, 8'h44, 1, 8'h6B, 1'b0, 1'b1, lat);
    check("rr_order_1", 96'(GNT), 96'(2'b10));
    xfer(2'b11, 8'h55, 8'h66, 0, 8'h7C, 1'b0, 1'b0, lat);
    check("rr_order_2", 96'(GNT), 96'(2'b01));

    // single requester, first poll hits: fixed latency, grant clears after FIN
    xfer(2'b01, 8'hA5, 8'h00, 0, 8'h3C, 1'b0, 1'b0, lat);
    check("latency", 96'(lat), 96'(6));
    check("done_gnt", 96'(GNT), 96'(2'b01));
    tick();
    check("gnt_clear", 96'(GNT), 96'(2'b00));
    check("rx_hold", 96'({RX_DATA, ERR}), 96'({8'h3C, 1'b0}));

    // status stuck at 0: timeout path
    xfer(2'b01, 8'h77, 8'h88, 1000, 8'h99, 1'b0, 1'b0, lat);
    tick();
    check("err_hold", 96'({RX_DATA, ERR}), 96'({8'h00, 1'b1}));

    // request dropped and TX changed right after grant
    xfer(2'b01, 8'hA5, 8'h12, 0, 8'hC3, 1'b1, 1'b0, lat);

    // randomized traffic
    for (int i = 0; i < 20; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      xfer(r, 8'($urandom), 8'($urandom), $urandom_range(0, 5), 8'($urandom), 1'b0, 1'b0, lat);
    end

    // reset during POLL abandons the transfer and reruns init
    wait_idle();
    cur_misses = 1000;
    last_served = 1'b0;
    exp_bus.push_back({1'b0, 32'h10, 32'h0000_0042});
    exp_bus.push_back({1'b1, 32'h04, 32'h0});
    REQ = 2'b01;
    TX0 = 8'h42;
    n = 0;
    while (!(MST_CEn === 1'b0 && MST_ADDR === 32'h04) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) fail("poll_wait", "no status poll seen, required poll");
    RESET = 1'b1;
    tick();
    check("midreset_outputs", 96'({GNT, DONE, ERR, RX_DATA, BUSY, MST_CEn, MST_WEn, MST_ADDR, MST_WDATA}),
          96'({2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0}));
    check("midreset_ops_left", 96'(exp_bus.size()), 96'(0));
    exp_done.delete();
    last_served = 1'b1;
    push_init();
    RESET = 1'b0;
    REQ = 2'b00;
    n = 0;
    while (BUSY !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("reinit_len", 96'(n), 96'(3));

    // priority restored to requester 0 after reset
    xfer(2'b11, 8'hD1, 8'hD2, 2, 8'hE7, 1'b0, 1'b0, lat);
    check("post_reset_gnt", 96'(GNT), 96'(2'b01));

    repeat (5) tick();
    check("bus_queue_empty", 96'(exp_bus.size()), 96'(0));
    check("done_queue_empty", 96'(exp_done.size()), 96'(0));

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/spi_xfer_arbiter.md
SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- MODE_CFG, 10'h0D7, value written to the SPCR (mode) register at init.
- CLK_DIV, 16'h0063, value written to the clock-divider register at init.
- TIMEOUT, 1023, maximum status polls per transfer before abort.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK in 1: the single clock.
- RESET in 1: synchronous, active-high reset.
- REQ in 2: per-requester transfer request; REQ[i] is held until DONE with GNT[i].
- TX0 in 8: requester 0 transmit byte.
- TX1 in 8: requester 1 transmit byte.
- GNT out 2: one-hot grant.
- DONE out 1: one-cycle pulse marking the end of a transfer.
- RX_DATA out 8: received byte, valid while DONE=1.
- ERR out 1: timeout flag, valid while DONE=1.
- BUSY out 1: high during init and while a transfer is in progress.
- MST_CEn out 1: SPI controller chip enable, active-low.
- MST_WEn out 1: SPI controller write enable, active-low.
- MST_ADDR out 32: SPI controller register byte address.
- MST_WDATA out 32: SPI controller write data.
- MST_RDATA in 32: SPI controller read data.

Function
REQ-003 The SPI controller register map SHALL be:
- 0x00: SPCR (mode).
- 0x04: SPSR (status); bit0=1 means the RX FIFO is non-empty.
- 0x0C: clock divider.
- 0x10: TX data.
- 0x14: RX data.
REQ-004 Each bus access SHALL be a single-cycle strobe with MST_CEn=0. A write also drives MST_WEn=0. A read drives MST_WEn=1, and MST_RDATA is sampled on the following cycle. MST_CEn and MST_WEn SHALL both be 1 in every non-strobe cycle.
REQ-005 The FSM states SHALL be INIT_MODE, INIT_CLK, IDLE, XFER_WR, POLL, CHK, RD_RX, CAP and FIN.
REQ-006 The first cycle after reset release SHALL be INIT_MODE: write 0x00 with {22'b0, MODE_CFG}.
REQ-007 INIT_CLK SHALL follow: write 0x0C with {16'b0, CLK_DIV}. The FSM then enters IDLE, and BUSY falls on IDLE entry.
REQ-008 In IDLE with REQ!=0, the next cycle SHALL be XFER_WR with:
- GNT set;
- the TX byte of the granted requester latched;
- a write to 0x10 with {24'b0, TX}.
REQ-009 Arbitration SHALL be round-robin. If only one REQ bit is set, that requester is granted. If both are set, the requester not served last is granted. After reset, requester 0 has priority.
REQ-010 XFER_WR SHALL be followed by POLL (read 0x04), then CHK (sample bit0):
- bit0=1: go to RD_RX.
- bit0=0 and poll count < TIMEOUT: return to POLL.
- otherwise: go to FIN with ERR=1 and RX_DATA=8'h00.
REQ-011 RD_RX SHALL read 0x14. CAP SHALL capture MST_RDATA[7:0] into RX_DATA. FIN SHALL pulse DONE for exactly one cycle.
REQ-012 In the best case (first poll hits), DONE SHALL assert 6 cycles after the cycle in which IDLE samples REQ.
REQ-013 GNT SHALL stay constant from XFER_WR through FIN and clear in the cycle after FIN. The FSM then returns to IDLE, and a pending request is granted on the next cycle.
REQ-014 The poll counter SHALL be 10 bits, clear on XFER_WR, increment on each POLL, and never wrap before the TIMEOUT compare.
REQ-015 Deasserting REQ mid-transfer SHALL NOT abort the transfer: DONE is still produced, and TX changes after the grant are ignored.
REQ-016 REQ SHALL be ignored during INIT_MODE and INIT_CLK and honoured once the FSM reaches IDLE.
REQ-017 RX_DATA and ERR SHALL hold their values after DONE until the next FIN.

Reset
REQ-018 On RESET=1 at a rising CLK edge, the block SHALL set:
- MST_CEn=1, MST_WEn=1, MST_ADDR=0, MST_WDATA=0;
- GNT=0, DONE=0, ERR=0, RX_DATA=0, BUSY=1;
- round-robin pointer so requester 0 has priority;
- poll count=0;
- state=INIT_MODE.
REQ-019 RESET asserted mid-transfer SHALL abandon the transfer with no DONE, and the full init sequence SHALL rerun after release.

Verification
REQ-020 Init after reset release SHALL produce exactly this sequence, then BUSY=0:
- cycle 1: write addr 0x00, data 0x0D7;
- cycle 2: write addr 0x0C, data 0x0063.
REQ-021 REQ=01 with TX0=8'hA5, status model bit0=1, RX=8'h3C:
- write 0x10 with 0xA5;
- read 0x04, then read 0x14;
- DONE 6 cycles after REQ is sampled, with RX_DATA=8'h3C, ERR=0, GNT=01.
REQ-022 REQ=11 held across transfers -> GNT order 01, 10, 01.
REQ-023 Status bit0 stuck at 0 with TIMEOUT=4 -> exactly 4 reads of 0x04, then DONE=1, ERR=1, RX_DATA=8'h00.
REQ-024 RESET pulsed during POLL -> all outputs at their reset values the next cycle, no DONE, init writes repeated.
REQ-025 REQ0 dropped and TX0 changed to 8'hFF right after the grant -> the TX write still carries the original byte, and DONE is still issued.
